vram_server: RTL

- Memory-side responder for the video controller's VRAM fetch interface.
- Serves the controller's pair of 16-bit word reads per 8-pixel slot (vram_addr1/vram_addr2 -> vram_dout1/vram_dout2).
- Interleaves Z80 byte reads and writes into the same single-port 16-bit external VRAM through a req/ack memory port.
- Sits between the video block, the CPU memory decoder and the SDRAM/SRAM controller; video always has priority.

---
 rtl/vram_server_if.sv | 23 ++
 rtl/vram_server.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vram_server_if.sv
// Memory-controller port of the VRAM server: one request/acknowledge channel
// to the single-port 16-bit external VRAM.
interface vram_server_if #(
  parameter int ADDR_W = 19
);
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic [15:0]       mem_dout;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_din,
    input  mem_dout, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_din,
    output mem_dout, mem_ack
  );
endinterface

// File: rtl/vram_server.sv
// VRAM arbiter: serves the video controller's word-pair fetches and Z80 byte
// accesses over one 16-bit memory port, with video always taking priority.
module vram_server #(
  parameter int ADDR_W     = 19,
  parameter int CPU_ADDR_W = 20
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_W-1:0]     vram_addr1,
  input  logic [ADDR_W-1:0]     vram_addr2,
  output logic [15:0]           vram_dout1,
  output logic [15:0]           vram_dout2,
  output logic                  vid_done,
  output logic                  vid_overrun,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [CPU_ADDR_W-1:0] cpu_addr,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  cpu_ack,
  output logic                  cpu_busy,
  vram_server_if.master         mem
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_V1 = 2'd1, S_V2 = 2'd2, S_CPU = 2'd3} state_t;

  state_t                  state_q, state_d;
  logic                    vid_pend_q, vid_pend_d, restart_q, restart_d;
  logic [ADDR_W-1:0]       va1_q, va1_d, va2_q, va2_d;
  logic [15:0]             t1_q, t1_d, dout1_q, dout1_d, dout2_q, dout2_d;
  logic                    vid_done_q, vid_done_d, overrun_q, overrun_d;
  logic                    busy_q, busy_d, cpu_we_q, cpu_we_d;
  logic [CPU_ADDR_W-1:0]   cpu_addr_q, cpu_addr_d;
  logic [7:0]              cpu_din_q, cpu_din_d, cpu_dout_q, cpu_dout_d;
  logic                    cpu_ack_q, cpu_ack_d;
  logic                    mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [1:0]              mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [15:0]             mem_din_q, mem_din_d;

  // Request capture, arbitration and per-state memory command generation.
  always_comb begin
    state_d    = state_q;    vid_pend_d = vid_pend_q; restart_d  = restart_q;
    va1_d      = va1_q;      va2_d      = va2_q;      t1_d       = t1_q;
    dout1_d    = dout1_q;    dout2_d    = dout2_q;    vid_done_d = 1'b0;
    overrun_d  = overrun_q;  busy_d     = busy_q;     cpu_we_d   = cpu_we_q;
    cpu_addr_d = cpu_addr_q; cpu_din_d  = cpu_din_q;  cpu_dout_d = cpu_dout_q;
    cpu_ack_d  = 1'b0;       mem_req_d  = mem_req_q;  mem_we_d   = mem_we_q;
    mem_be_d   = mem_be_q;   mem_addr_d = mem_addr_q; mem_din_d  = mem_din_q;

    // A new pair replaces a pending one; an in-flight pair is marked stale.
    if (vid_req) begin
      va1_d      = vram_addr1;
      va2_d      = vram_addr2;
      vid_pend_d = 1'b1;
      if (vid_pend_q) begin
        overrun_d = 1'b1;
        if ((state_q == S_V1) || (state_q == S_V2)) begin
          restart_d = 1'b1;
        end else begin
          restart_d = restart_q;
        end
      end else begin
        overrun_d = overrun_q;
      end
    end else begin
      vid_pend_d = vid_pend_q;
    end

    if (!busy_q && (cpu_rd || cpu_wr)) begin
      busy_d     = 1'b1;
      cpu_we_d   = cpu_wr;
      cpu_addr_d = cpu_addr;
      cpu_din_d  = cpu_din;
    end else begin
      busy_d = busy_q;
    end

    case (state_q)
      S_IDLE: begin
        if (vid_pend_q) begin
          state_d    = S_V1;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_be_d   = 2'b11;
          mem_addr_d = va1_d;
          mem_din_d  = 16'h0000;
          restart_d  = 1'b0;
        end else if (busy_q) begin
          state_d    = S_CPU;
          mem_req_d  = 1'b1;
          mem_we_d   = cpu_we_q;
          mem_be_d   = cpu_we_q ? (cpu_addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
          mem_addr_d = cpu_addr_q[CPU_ADDR_W-1:1];
          mem_din_d  = {cpu_din_q, cpu_din_q};
        end else begin
          mem_req_d = 1'b0;
        end
      end
      S_V1: begin
        if (mem.mem_ack) begin
          if (restart_d) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
            restart_d = 1'b0;
          end else begin
            t1_d       = mem.mem_dout;
            state_d    = S_V2;
            mem_addr_d = va2_q;
          end
        end else begin
          state_d = S_V1;
        end
      end
      S_V2: begin
        if (mem.mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (restart_d) begin
            restart_d = 1'b0;
          end else begin
            dout1_d    = t1_q;
            dout2_d    = mem.mem_dout;
            vid_done_d = 1'b1;
            vid_pend_d = 1'b0;
          end
        end else begin
          state_d = S_V2;
        end
      end
      S_CPU: begin
        if (mem.mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          cpu_ack_d = 1'b1;
          busy_d    = 1'b0;
          if (!cpu_we_q) begin
            cpu_dout_d = cpu_addr_q[0] ? mem.mem_dout[15:8] : mem.mem_dout[7:0];
          end else begin
            cpu_dout_d = cpu_dout_q;
          end
        end else begin
          state_d = S_CPU;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE; vid_pend_q <= 1'b0;     restart_q  <= 1'b0;
      va1_q      <= '0;     va2_q      <= '0;       t1_q       <= 16'h0000;
      dout1_q    <= 16'h0000; dout2_q  <= 16'h0000; vid_done_q <= 1'b0;
      overrun_q  <= 1'b0;   busy_q     <= 1'b0;     cpu_we_q   <= 1'b0;
      cpu_addr_q <= '0;     cpu_din_q  <= 8'h00;    cpu_dout_q <= 8'h00;
      cpu_ack_q  <= 1'b0;   mem_req_q  <= 1'b0;     mem_we_q   <= 1'b0;
      mem_be_q   <= 2'b00;  mem_addr_q <= '0;       mem_din_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;    vid_pend_q <= vid_pend_d; restart_q  <= restart_d;
      va1_q      <= va1_d;      va2_q      <= va2_d;      t1_q       <= t1_d;
      dout1_q    <= dout1_d;    dout2_q    <= dout2_d;    vid_done_q <= vid_done_d;
      overrun_q  <= overrun_d;  busy_q     <= busy_d;     cpu_we_q   <= cpu_we_d;
      cpu_addr_q <= cpu_addr_d; cpu_din_q  <= cpu_din_d;  cpu_dout_q <= cpu_dout_d;
      cpu_ack_q  <= cpu_ack_d;  mem_req_q  <= mem_req_d;  mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;   mem_addr_q <= mem_addr_d; mem_din_q  <= mem_din_d;
    end
  end

  assign vram_dout1   = dout1_q;
  assign vram_dout2   = dout2_q;
  assign vid_done     = vid_done_q;
  assign vid_overrun  = overrun_q;
  assign cpu_dout     = cpu_dout_q;
  assign cpu_ack      = cpu_ack_q;
  assign cpu_busy     = busy_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_we   = mem_we_q;
  assign mem.mem_be   = mem_be_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_din  = mem_din_q;
endmodule
